// File: rtl/calc_alu_seq.sv
// Calculator ALU sequencer: runs ADD/SUB/MUL/DIV over one shared
// external ripple-carry adder, one adder pass per clock.
module calc_alu_seq #(
    parameter int W  = 20,
    parameter int MW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic [MW-1:0] remainder,
    output logic          overflow,
    output logic          div_err,
    output logic [W-1:0]  add_n1,
    output logic [W-1:0]  add_n2,
    output logic          add_cin,
    input  logic [W-1:0]  add_s,
    input  logic          add_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    state_t        state;
    state_t        state_n;
    logic [1:0]    op_r;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [4:0]    cnt;
    logic [MW:0]   rem_r;

    logic          div_zero;
    logic [4:0]    last;
    logic          is_last;
    logic [4:0]    didx;
    logic [MW+1:0] rs;
    logic [W-1:0]  mul_pp;
    logic [MW:0]   rem_nx;

    always_comb begin
        div_zero = (b[MW-1:0] == '0);
        unique case (op_r)
            OP_MUL:  last = 5'(MW - 1);
            OP_DIV:  last = 5'(W - 1);
            default: last = 5'd0;
        endcase
        is_last = (cnt == last);
        didx    = 5'(W - 1) - cnt;
        // Shifted-in dividend bit forms the trial partial remainder
        rs      = {rem_r, a_r[didx]};
        mul_pp  = b_r[cnt] ? ({{(W-MW){1'b0}}, a_r[MW-1:0]} << cnt) : '0;
        rem_nx  = add_cout ? add_s[MW:0] : rs[MW:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_n = (op == OP_DIV && div_zero) ? DONE : EXEC;
            end
            EXEC:    if (is_last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        add_n1  = '0;
        add_n2  = '0;
        add_cin = 1'b0;
        if (state == EXEC) begin
            unique case (op_r)
                OP_ADD: begin
                    add_n1 = a_r;
                    add_n2 = b_r;
                end
                OP_SUB: begin
                    add_n1  = a_r;
                    add_n2  = ~b_r;
                    add_cin = 1'b1;
                end
                OP_MUL: begin
                    add_n1 = result;
                    add_n2 = mul_pp;
                end
                default: begin
                    add_n1  = {{(W-MW-2){1'b0}}, rs};
                    add_n2  = ~{{(W-MW){1'b0}}, b_r[MW-1:0]};
                    add_cin = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= OP_ADD;
            a_r       <= '0;
            b_r       <= '0;
            cnt       <= '0;
            rem_r     <= '0;
            result    <= '0;
            remainder <= '0;
            overflow  <= 1'b0;
            div_err   <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                op_r      <= op;
                a_r       <= a;
                b_r       <= b;
                cnt       <= '0;
                rem_r     <= '0;
                remainder <= '0;
                overflow  <= 1'b0;
                div_err   <= (op == OP_DIV) && div_zero;
                result    <= (op == OP_DIV && div_zero) ? '1 : '0;
            end
        end else if (state == EXEC) begin
            cnt <= cnt + 5'd1;
            unique case (op_r)
                OP_ADD: begin
                    result   <= add_s;
                    overflow <= add_cout;
                end
                OP_SUB: begin
                    result   <= add_s;
                    overflow <= ~add_cout;
                end
                OP_MUL: result <= add_s;
                default: begin
                    rem_r  <= rem_nx;
                    result <= {result[W-2:0], add_cout};
                    if (is_last) remainder <= rem_nx[MW-1:0];
                end
            endcase
        end
    end

endmodule
